psx_ddr_arbiter: RTL and testbench

- Parametrised N-client successor to the single-client PSX DDR bridge.
- Accepts 32-byte-block read/write commands from NCLIENT requesters (GPU, MDEC, CPU path, …) through the existing 256-bit block interface.
- Arbitrates between them, round-robin or fixed priority.
- Converts each granted command into an Avalon-MM burst of 64-bit beats, and returns read data to the issuing client only.

---
 rtl/psx_ddr_arbiter_if.sv | 40 ++++
 rtl/psx_ddr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_psx_ddr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psx_ddr_arbiter_if.sv
// Client block interface plus Avalon-MM master signals for psx_ddr_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the clients and the memory model.
interface psx_ddr_arbiter_if #(
  parameter int NCLIENT = 2,
  parameter int ADR_W   = 15
) ();
  logic [NCLIENT-1:0]       i_command;
  logic [NCLIENT-1:0]       i_write;
  logic [2*NCLIENT-1:0]     i_commandSize;
  logic [ADR_W*NCLIENT-1:0] i_adr;
  logic [3*NCLIENT-1:0]     i_subAdr;
  logic [16*NCLIENT-1:0]    i_writeMask;
  logic [256*NCLIENT-1:0]   i_dataClient;
  logic [NCLIENT-1:0]       o_busy;
  logic [NCLIENT-1:0]       o_dataValid;
  logic [255:0]             o_dataClient;
  logic [ADR_W+1:0]         o_targetAddr;
  logic [2:0]               o_burstLength;
  logic                     i_busyMem;
  logic                     o_writeEnableMem;
  logic                     o_readEnableMem;
  logic [63:0]              o_dataMem;
  logic [7:0]               o_byteEnableMem;
  logic                     i_dataValidMem;
  logic [63:0]              i_dataMem;

  modport slave (
    input  i_command, i_write, i_commandSize, i_adr, i_subAdr, i_writeMask, i_dataClient,
    input  i_busyMem, i_dataValidMem, i_dataMem,
    output o_busy, o_dataValid, o_dataClient, o_targetAddr, o_burstLength,
    output o_writeEnableMem, o_readEnableMem, o_dataMem, o_byteEnableMem
  );

  modport master (
    output i_command, i_write, i_commandSize, i_adr, i_subAdr, i_writeMask, i_dataClient,
    output i_busyMem, i_dataValidMem, i_dataMem,
    input  o_busy, o_dataValid, o_dataClient, o_targetAddr, o_burstLength,
    input  o_writeEnableMem, o_readEnableMem, o_dataMem, o_byteEnableMem
  );
endinterface

// File: rtl/psx_ddr_arbiter.sv
// N-client arbiter: takes 32-byte block commands and turns each one into an Avalon-MM burst of 64-bit beats.
// Only one transaction is outstanding at a time.
//
// state     | meaning
// S_IDLE    | arbitrate, accept one command
// S_WR      | issue write beats, advance on !waitrequest
// S_RD_REQ  | hold read request until accepted
// S_RD_DATA | collect readdatavalid beats into the block buffer
// S_DONE    | one-cycle dataValid pulse to the issuing client
module psx_ddr_arbiter #(
  parameter int NCLIENT   = 2,
  parameter int ADR_W     = 15,
  parameter int PRIO_MODE = 0
) (
  input logic              clk,
  input logic              i_nrst,
  psx_ddr_arbiter_if.slave bus
);
  localparam int ID_W = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_DATA, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [1:0]       start_q, start_d;
  logic [1:0]       beat_q, beat_d;
  logic [1:0]       rem_q, rem_d;
  logic [2:0]       blen_q, blen_d;
  logic [15:0]      mask_q, mask_d;
  logic [255:0]     data_q, data_d;
  logic [255:0]     rbuf_q, rbuf_d;

  logic [ID_W-1:0]  grant;
  logic             grant_vld;
  logic             size8;
  logic             unused_sub0;

  // Only subAdr[2:1] selects a lane, so bit 0 of each client's sub-address is not used.
  assign unused_sub0 = ^(bus.i_subAdr & {NCLIENT{3'b001}});

  // Round-robin search starts one past the last winner. Fixed priority scans from index 0.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NCLIENT; i++) begin
      if (PRIO_MODE != 0) begin
        idx = i - 1;
      end else begin
        idx = int'(ptr_q) + i;
        if (idx >= NCLIENT) idx = idx - NCLIENT;
      end
      if (!grant_vld && bus.i_command[idx]) begin
        grant_vld = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bus.o_busy = '1;
    if (i_nrst && state_q == S_IDLE && grant_vld) bus.o_busy[grant] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    adr_d   = adr_q;
    start_d = start_q;
    beat_d  = beat_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    mask_d  = mask_q;
    data_d  = data_q;
    rbuf_d  = rbuf_q;
    size8   = (bus.i_commandSize[2*int'(grant) +: 2] == 2'd0);
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ptr_d   = grant;
          id_d    = grant;
          adr_d   = bus.i_adr[ADR_W*int'(grant) +: ADR_W];
          start_d = size8 ? bus.i_subAdr[3*int'(grant)+1 +: 2] : 2'd0;
          beat_d  = start_d;
          rem_d   = size8 ? 2'd0 : 2'd3;
          blen_d  = size8 ? 3'd1 : 3'd4;
          mask_d  = bus.i_writeMask[16*int'(grant) +: 16];
          data_d  = bus.i_dataClient[256*int'(grant) +: 256];
          state_d = bus.i_write[grant] ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        if (!bus.i_busyMem) begin
          if (rem_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
            rem_d  = rem_q - 2'd1;
          end
        end
      end
      S_RD_REQ: begin
        if (!bus.i_busyMem) begin
          rbuf_d  = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.i_dataValidMem) begin
          rbuf_d[64*int'(beat_q) +: 64] = bus.i_dataMem;
          if (rem_q == 2'd0) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 2'd1;
            rem_d  = rem_q - 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(NCLIENT - 1);
      id_q    <= '0;
      adr_q   <= '0;
      start_q <= '0;
      beat_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      adr_q   <= adr_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Each halfword mask bit drives the enables for both of its bytes.
  always_comb begin
    bus.o_writeEnableMem = (state_q == S_WR);
    bus.o_readEnableMem  = (state_q == S_RD_REQ);
    bus.o_dataMem        = '0;
    bus.o_byteEnableMem  = '0;
    if (state_q == S_WR) begin
      bus.o_dataMem = data_q[64*int'(beat_q) +: 64];
      for (int i = 0; i < 4; i++) begin
        bus.o_byteEnableMem[2*i +: 2] = {2{mask_q[4*int'(beat_q) + i]}};
      end
    end
    bus.o_dataValid = '0;
    if (state_q == S_DONE) bus.o_dataValid[id_q] = 1'b1;
    bus.o_dataClient  = rbuf_q;
    bus.o_targetAddr  = {adr_q, start_q};
    bus.o_burstLength = blen_q;
  end
endmodule

// File: tb/tb_psx_ddr_arbiter.sv
// Bench for psx_ddr_arbiter. bus0 drives a round-robin instance and bus1 drives a fixed-priority instance.
// Expected beats, read blocks and grant orders go into queues when stimulus is applied and are compared as the DUT produces them.
module tb_psx_ddr_arbiter;
  logic clk;
  logic rst_n;

  psx_ddr_arbiter_if #(.NCLIENT(2), .ADR_W(15)) bus0 ();
  psx_ddr_arbiter_if #(.NCLIENT(2), .ADR_W(15)) bus1 ();

  psx_ddr_arbiter #(.NCLIENT(2), .ADR_W(15), .PRIO_MODE(0)) u_rr (
    .clk(clk), .i_nrst(rst_n), .bus(bus0.slave)
  );
  psx_ddr_arbiter #(.NCLIENT(2), .ADR_W(15), .PRIO_MODE(1)) u_fp (
    .clk(clk), .i_nrst(rst_n), .bus(bus1.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  beat_t        exp_beats[$];
  logic [255:0] exp_blocks[$];
  logic [255:0] last_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] be_of(input logic [15:0] m, input int b);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i]   = m[4*b + i];
      r[2*i+1] = m[4*b + i];
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    bus0.i_command = '0; bus0.i_write = '0; bus0.i_commandSize = '0; bus0.i_adr = '0;
    bus0.i_subAdr = '0; bus0.i_writeMask = '0; bus0.i_dataClient = '0;
    bus0.i_busyMem = 1'b0; bus0.i_dataValidMem = 1'b0; bus0.i_dataMem = '0;
    bus1.i_command = '0; bus1.i_write = '0; bus1.i_commandSize = '0; bus1.i_adr = '0;
    bus1.i_subAdr = '0; bus1.i_writeMask = '0; bus1.i_dataClient = '0;
    bus1.i_busyMem = 1'b0; bus1.i_dataValidMem = 1'b0; bus1.i_dataMem = '0;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [1:0] sz, input logic [14:0] adr,
                         input logic [2:0] sub, input logic [15:0] mask, input logic [255:0] data);
    bus0.i_command[c]               = 1'b1;
    bus0.i_write[c]                 = wr;
    bus0.i_commandSize[2*c +: 2]    = sz;
    bus0.i_adr[15*c +: 15]          = adr;
    bus0.i_subAdr[3*c +: 3]         = sub;
    bus0.i_writeMask[16*c +: 16]    = mask;
    bus0.i_dataClient[256*c +: 256] = data;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (bus0.o_busy !== 2'b11) begin n_fail++; $display("FAIL reset_busy: got %b want 11", bus0.o_busy); end
    n_checks++;
    if ({bus0.o_writeEnableMem, bus0.o_readEnableMem, bus0.o_dataValid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got we=%b re=%b dv=%b want 0", bus0.o_writeEnableMem, bus0.o_readEnableMem, bus0.o_dataValid);
    end
    n_checks++;
    if ({bus0.o_dataClient, bus0.o_targetAddr, bus0.o_burstLength, bus0.o_dataMem, bus0.o_byteEnableMem} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h len=%0d be=%h want 0", bus0.o_targetAddr, bus0.o_burstLength, bus0.o_byteEnableMem);
    end
    apply_reset();
  endtask

  // Accept one write, then drive waitrequest and check every beat against the scoreboard.
  task automatic do_write(input string tag, input int c, input logic [1:0] sz, input logic [14:0] adr,
                          input logic [2:0] sub, input logic [15:0] mask, input logic [255:0] data,
                          input int wait_beat, input int wait_cycles);
    int start, nb, done, waited, cyc;
    beat_t bt;
    start = (sz == 2'd0) ? int'(sub[2:1]) : 0;
    nb    = (sz == 2'd0) ? 1 : 4;
    for (int k = 0; k < nb; k++) begin
      bt.data = data[64*(start+k) +: 64];
      bt.be   = be_of(mask, start + k);
      exp_beats.push_back(bt);
    end
    @(posedge clk); #1;
    set_req(c, 1'b1, sz, adr, sub, mask, data);
    cyc = 0;
    @(negedge clk);
    while (bus0.o_busy[c] && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (bus0.o_busy[c] !== 1'b0) begin n_fail++; $display("FAIL %s accept: busy=%b want 0", tag, bus0.o_busy); end
    @(posedge clk); #1;
    bus0.i_command[c] = 1'b0;
    done = 0; waited = 0; cyc = 0;
    while (done < nb && cyc < 40) begin
      bus0.i_busyMem = (done == wait_beat && waited < wait_cycles);
      @(negedge clk);
      n_checks++;
      if (bus0.o_writeEnableMem !== 1'b1) begin
        n_fail++; $display("FAIL %s we cycle %0d: got %b want 1", tag, cyc, bus0.o_writeEnableMem);
      end else begin
        bt = exp_beats[0];
        n_checks++;
        if (bus0.o_dataMem !== bt.data) begin
          n_fail++; $display("FAIL %s data beat %0d: got %h want %h", tag, done, bus0.o_dataMem, bt.data);
        end
        n_checks++;
        if (bus0.o_byteEnableMem !== bt.be) begin
          n_fail++; $display("FAIL %s be beat %0d: got %h want %h", tag, done, bus0.o_byteEnableMem, bt.be);
        end
        n_checks++;
        if (bus0.o_targetAddr !== {adr, 2'(start)} || bus0.o_burstLength !== 3'(nb)) begin
          n_fail++; $display("FAIL %s addr/len: got %h/%0d want %h/%0d", tag, bus0.o_targetAddr, bus0.o_burstLength, {adr, 2'(start)}, nb);
        end
        n_checks++;
        if (bus0.o_busy[c] !== 1'b1) begin n_fail++; $display("FAIL %s busy_in_burst: got 0 want 1", tag); end
        if (!bus0.i_busyMem) begin void'(exp_beats.pop_front()); done++; end
        else waited++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus0.i_busyMem = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus0.o_writeEnableMem !== 1'b0 || bus0.o_dataValid !== 2'b00) begin
      n_fail++; $display("FAIL %s end: got we=%b dv=%b want 0/00", tag, bus0.o_writeEnableMem, bus0.o_dataValid);
    end
    exp_beats.delete();
  endtask

  // Accept one read, hold waitrequest for rd_wait cycles, return beats, and check the completion pulse and block.
  task automatic do_read(input string tag, input int c, input logic [1:0] sz, input logic [14:0] adr,
                         input logic [2:0] sub, input logic [255:0] beats, input int rd_wait);
    int start, nb, waited, cyc;
    logic [255:0] blk;
    start = (sz == 2'd0) ? int'(sub[2:1]) : 0;
    nb    = (sz == 2'd0) ? 1 : 4;
    blk   = '0;
    for (int k = 0; k < nb; k++) blk[64*(start+k) +: 64] = beats[64*k +: 64];
    exp_blocks.push_back(blk);
    @(posedge clk); #1;
    set_req(c, 1'b0, sz, adr, sub, 16'h0, '0);
    cyc = 0;
    @(negedge clk);
    while (bus0.o_busy[c] && cyc < 50) begin @(negedge clk); cyc++; end
    n_checks++;
    if (bus0.o_busy[c] !== 1'b0) begin n_fail++; $display("FAIL %s accept: busy=%b want 0", tag, bus0.o_busy); end
    @(posedge clk); #1;
    bus0.i_command[c] = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      bus0.i_busyMem = (waited < rd_wait);
      @(negedge clk);
      n_checks++;
      if (bus0.o_readEnableMem !== 1'b1 || bus0.o_targetAddr !== {adr, 2'(start)} || bus0.o_burstLength !== 3'(nb)) begin
        n_fail++; $display("FAIL %s req: got re=%b addr=%h len=%0d want 1/%h/%0d", tag, bus0.o_readEnableMem,
                           bus0.o_targetAddr, bus0.o_burstLength, {adr, 2'(start)}, nb);
      end
      @(posedge clk); #1;
      if (!bus0.i_busyMem) break;
      waited++;
    end
    bus0.i_busyMem = 1'b0;
    for (int k = 0; k < nb; k++) begin
      bus0.i_dataValidMem = 1'b1;
      bus0.i_dataMem      = beats[64*k +: 64];
      @(negedge clk);
      n_checks++;
      if (bus0.o_dataValid !== 2'b00 || bus0.o_readEnableMem !== 1'b0) begin
        n_fail++; $display("FAIL %s early: got dv=%b re=%b want 00/0", tag, bus0.o_dataValid, bus0.o_readEnableMem);
      end
      @(posedge clk); #1;
    end
    bus0.i_dataValidMem = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (bus0.o_dataValid === 2'b00 && cyc < 8) begin @(negedge clk); cyc++; end
    n_checks++;
    if (bus0.o_dataValid !== 2'(1 << c) || cyc != 0) begin
      n_fail++; $display("FAIL %s dv: got %b after %0d extra cycles want %b after 0", tag, bus0.o_dataValid, cyc, 2'(1 << c));
    end
    n_checks++;
    if (bus0.o_dataClient !== exp_blocks[0]) begin
      n_fail++; $display("FAIL %s block: got %h want %h", tag, bus0.o_dataClient, exp_blocks[0]);
    end
    last_rd = exp_blocks.pop_front();
    @(negedge clk);
    n_checks++;
    if (bus0.o_dataValid !== 2'b00 || bus0.o_dataClient !== last_rd) begin
      n_fail++; $display("FAIL %s pulse/hold: got dv=%b block=%h want 00/%h", tag, bus0.o_dataValid, bus0.o_dataClient, last_rd);
    end
  endtask

  task automatic test_write_burst();
    do_write("wr32", 0, 2'd1, 15'h0123, 3'b000, 16'hFFFF, rand256(), 9, 0);
  endtask

  task automatic test_read_8byte();
    do_read("rd8", 1, 2'd0, 15'h0010, 3'b100, {192'h0, 64'hDEADBEEF_CAFEF00D}, 0);
  endtask

  task automatic test_read_32_wait();
    do_read("rd32", 0, 2'd3, 15'h7ABC, 3'b110, rand256(), 2);
  endtask

  task automatic test_write_wait();
    do_write("wrwait", 1, 2'd1, 15'h0200, 3'b000, 16'h0F30, rand256(), 2, 3);
    n_checks++;
    if (bus0.o_dataClient !== last_rd) begin
      n_fail++; $display("FAIL rd_hold_over_write: got %h want %h", bus0.o_dataClient, last_rd);
    end
  endtask

  task automatic test_write_8byte();
    do_write("wr8", 0, 2'd0, 15'h0033, 3'b011, 16'h00F0, rand256(), 9, 0);
  endtask

  task automatic test_arbitration();
    int exp_rr[$];
    int exp_fp[$];
    int cyc, got;
    apply_reset();
    exp_rr = '{0, 1, 0, 1};
    exp_fp = '{0, 0, 0, 0};
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd0, 15'h0001, 3'b000, 16'hFFFF, rand256());
    set_req(1, 1'b1, 2'd0, 15'h0002, 3'b000, 16'hFFFF, rand256());
    bus1.i_command = bus0.i_command; bus1.i_write = bus0.i_write; bus1.i_commandSize = bus0.i_commandSize;
    bus1.i_adr = bus0.i_adr; bus1.i_subAdr = bus0.i_subAdr; bus1.i_writeMask = bus0.i_writeMask;
    bus1.i_dataClient = bus0.i_dataClient;
    cyc = 0;
    while ((exp_rr.size() > 0 || exp_fp.size() > 0) && cyc < 40) begin
      @(negedge clk);
      if (bus0.o_busy != 2'b11 && exp_rr.size() > 0) begin
        got = bus0.o_busy[0] ? 1 : 0;
        n_checks++;
        if (got != exp_rr[0]) begin n_fail++; $display("FAIL rr_grant: got %0d want %0d", got, exp_rr[0]); end
        void'(exp_rr.pop_front());
      end
      if (bus1.o_busy != 2'b11 && exp_fp.size() > 0) begin
        got = bus1.o_busy[0] ? 1 : 0;
        n_checks++;
        if (got != exp_fp[0]) begin n_fail++; $display("FAIL fp_grant: got %0d want %0d", got, exp_fp[0]); end
        void'(exp_fp.pop_front());
      end
      n_checks++;
      if (bus1.o_busy[1] !== 1'b1) begin n_fail++; $display("FAIL fp_starve: client1 busy got 0 want 1"); end
      cyc++;
    end
    n_checks++;
    if (exp_rr.size() != 0 || exp_fp.size() != 0) begin
      n_fail++; $display("FAIL arb_timeout: got %0d/%0d grants pending want 0/0", exp_rr.size(), exp_fp.size());
    end
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] beats;
    beats = rand256();
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'd1, 15'h0055, 3'b000, 16'h0, '0);
    @(negedge clk);
    n_checks++;
    if (bus0.o_busy !== 2'b01) begin n_fail++; $display("FAIL mid_accept: got %b want 01", bus0.o_busy); end
    @(posedge clk); #1;
    bus0.i_command[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus0.i_dataValidMem = 1'b1;
      bus0.i_dataMem      = beats[64*k +: 64];
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.o_busy !== 2'b11) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 11", bus0.o_busy); end
    n_checks++;
    if ({bus0.o_writeEnableMem, bus0.o_readEnableMem, bus0.o_dataValid, bus0.o_targetAddr, bus0.o_burstLength} !== '0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got re=%b addr=%h len=%0d want 0", bus0.o_readEnableMem, bus0.o_targetAddr, bus0.o_burstLength);
    end
    n_checks++;
    if (bus0.o_dataClient !== '0) begin n_fail++; $display("FAIL mid_rst_block: got %h want 0", bus0.o_dataClient); end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.o_dataValid !== 2'b00 || bus0.o_dataClient !== '0 || bus0.o_readEnableMem !== 1'b0) begin
        n_fail++; $display("FAIL stale_dv: got dv=%b block=%h want 00/0", bus0.o_dataValid, bus0.o_dataClient);
      end
    end
    @(posedge clk); #1;
    bus0.i_dataValidMem = 1'b0;
    set_req(0, 1'b1, 2'd0, 15'h0066, 3'b010, 16'hFFFF, rand256());
    set_req(1, 1'b1, 2'd0, 15'h0077, 3'b000, 16'hFFFF, rand256());
    @(negedge clk);
    n_checks++;
    if (bus0.o_busy !== 2'b10) begin n_fail++; $display("FAIL post_rst_grant: got %b want 10", bus0.o_busy); end
    @(posedge clk); #1;
    bus0.i_command = '0;
    @(negedge clk);
    n_checks++;
    if (bus0.o_writeEnableMem !== 1'b1 || bus0.o_targetAddr !== {15'h0066, 2'd1}) begin
      n_fail++; $display("FAIL post_rst_wr: got we=%b addr=%h want 1/%h", bus0.o_writeEnableMem, bus0.o_targetAddr, {15'h0066, 2'd1});
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    last_rd = '0;
    apply_reset();
    test_reset();
    test_write_burst();
    test_read_8byte();
    test_read_32_wait();
    test_write_wait();
    test_write_8byte();
    test_arbitration();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
